// File: rtl/vram_fill_arb.sv
// VRAM write-port owner: arbitrates CPU pixel writes against a clipped rectangle-fill engine.
// Optional checkerboard fill enabled by defining VRAM_FILL_PATTERN_EN.
module vram_fill_arb #(
    parameter int WIDTH      = 640,
    parameter int HEIGHT     = 240,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [19:0] cpu_addr,
    input  logic [7:0]  cpu_data,
    input  logic        cpu_we,
    output logic        cpu_ready,
    input  logic        fill_rq,
    input  logic [9:0]  fill_x,
    input  logic [8:0]  fill_y,
    input  logic [9:0]  fill_w,
    input  logic [8:0]  fill_h,
    input  logic [7:0]  fill_color,
`ifdef VRAM_FILL_PATTERN_EN
    input  logic [7:0]  fill_color2,
    input  logic        fill_pat,
`endif
    output logic        fill_busy,
    output logic        fill_ack,
    output logic [19:0] vmem_addr,
    output logic [7:0]  vmem_data,
    output logic        vmem_we
);

    // state  | meaning
    // S_IDLE | waiting for fill_rq; CPU owns every slot
    // S_RUN  | fill in progress; CPU first, fill forced after STARVE_MAX CPU wins
    // S_DONE | one-cycle fill_ack pulse
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t      state, next_state;
    logic [9:0]  fx, cx;
    logic [8:0]  cy;
    logic [10:0] x1, y1;
    logic [19:0] row_base;
    logic [7:0]  color;
    logic [3:0]  starve;
    logic [7:0]  pix;
    logic [10:0] sum_x, sum_y, clip_x, clip_y;
    logic        empty, fill_slot, last_col, last_row;

    // 11-bit sums so a rectangle hanging off the screen edge cannot wrap
    assign sum_x  = {1'b0, fill_x} + {1'b0, fill_w};
    assign sum_y  = {2'b0, fill_y} + {2'b0, fill_h};
    assign clip_x = (sum_x > 11'(WIDTH))  ? 11'(WIDTH)  : sum_x;
    assign clip_y = (sum_y > 11'(HEIGHT)) ? 11'(HEIGHT) : sum_y;
    assign empty  = ({1'b0, fill_x} >= 11'(WIDTH)) || ({2'b0, fill_y} >= 11'(HEIGHT)) ||
                    (fill_w == 10'd0) || (fill_h == 9'd0);

    assign cpu_ready = cpu_we && !(state == S_RUN && starve == 4'(STARVE_MAX));
    assign fill_slot = (state == S_RUN) && !cpu_ready;
    assign last_col  = ({1'b0, cx} + 11'd1) == x1;
    assign last_row  = ({2'b0, cy} + 11'd1) == y1;
    assign fill_busy = (state == S_RUN);
    assign fill_ack  = (state == S_DONE);

`ifdef VRAM_FILL_PATTERN_EN
    logic [7:0] color2;
    logic       pat;
    assign pix = (pat && (cx[0] ^ cy[0])) ? color2 : color;
`else
    assign pix = color;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (fill_rq) next_state = empty ? S_DONE : S_RUN;
            S_RUN:  if (fill_slot && last_col && last_row) next_state = S_DONE;
            S_DONE: next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fx        <= '0;
            cx        <= '0;
            cy        <= '0;
            x1        <= '0;
            y1        <= '0;
            row_base  <= '0;
            color     <= '0;
            starve    <= '0;
            vmem_addr <= '0;
            vmem_data <= '0;
            vmem_we   <= 1'b0;
`ifdef VRAM_FILL_PATTERN_EN
            color2    <= '0;
            pat       <= 1'b0;
`endif
        end else begin
            starve <= (state == S_RUN && cpu_ready) ? starve + 4'd1 : 4'd0;
            if (state == S_IDLE && fill_rq) begin
                fx       <= fill_x;
                cx       <= fill_x;
                cy       <= fill_y;
                x1       <= clip_x;
                y1       <= clip_y;
                row_base <= 20'(fill_y) * 20'(WIDTH);
                color    <= fill_color;
`ifdef VRAM_FILL_PATTERN_EN
                color2   <= fill_color2;
                pat      <= fill_pat;
`endif
            end else if (fill_slot) begin
                if (last_col) begin
                    cx       <= fx;
                    cy       <= cy + 9'd1;
                    row_base <= row_base + 20'(WIDTH);
                end else begin
                    cx <= cx + 10'd1;
                end
            end
            vmem_we <= cpu_ready || fill_slot;
            if (cpu_ready) begin
                vmem_addr <= cpu_addr;
                vmem_data <= cpu_data;
            end else if (fill_slot) begin
                vmem_addr <= row_base + 20'(cx);
                vmem_data <= pix;
            end
        end
    end

endmodule

// File: doc/vram_fill_arb.md
Name: vram_fill_arb

Overview:
- Owns the VRAM write port (p1 addr/data/we) and shares it between CPU pixel writes and a rectangle-fill engine.
- The fill engine writes a constant colour over a clipped rectangle; a screen clear is the full-screen rectangle.
- Sits between the CPU bus and the frame buffer; vram_fill_arb is the only block that drives the p1 port.
- The CPU has priority, with a starvation bound so a fill always progresses.

Parameters:
- WIDTH, 640, pixels per row.
- HEIGHT, 240, rows; WIDTH*HEIGHT = 153600 bytes of VRAM.
- STARVE_MAX, 4, maximum consecutive CPU-won cycles while a fill is running (range 1..15).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- cpu_addr  in  20  CPU write address (linear)
- cpu_data  in  8  CPU write data
- cpu_we  in  1  CPU write request; held with addr/data until cpu_ready
- cpu_ready  out  1  combinational; request accepted this cycle
- fill_rq  in  1  start fill; sampled only in IDLE
- fill_x  in  10  left column
- fill_y  in  9  top row
- fill_w  in  10  width in pixels
- fill_h  in  9  height in rows
- fill_color  in  8  fill byte
- fill_busy  out  1  fill in progress
- fill_ack  out  1  one-cycle done pulse
- vmem_addr  out  20  registered VRAM write address
- vmem_data  out  8  registered VRAM write data
- vmem_we  out  1  registered VRAM write enable

Behaviour:
- Reset (async, rst=0): state IDLE; all outputs 0; internal counters 0.
- Reset mid-fill aborts with no ack. Writes already issued stay in VRAM.
- Write latency: a slot granted in cycle N appears on vmem_* in cycle N+1. At most one write per cycle.
- State IDLE:
  - On fill_rq, latch the inputs and clip: x1 = min(fill_x+fill_w, WIDTH), y1 = min(fill_y+fill_h, HEIGHT). Use 11-bit sums so the addition does not wrap.
  - Empty rectangle (fill_x>=WIDTH, fill_y>=HEIGHT, fill_w==0 or fill_h==0): go to DONE with zero writes.
  - Otherwise go to RUN with cx=fill_x, cy=fill_y, row_base=fill_y*WIDTH.
  - fill_busy=1 from the cycle after fill_rq is accepted until DONE.
- State RUN:
  - Fill pixel address = row_base+cx. row_base advances by +WIDTH per row; no multiplier after setup.
  - On a fill slot: cx++. When cx+1==x1, set cx=fill_x, cy++, row_base+=WIDTH. When cy+1==y1 on the last column, go to DONE.
- State DONE: fill_ack=1 and fill_busy=0 for exactly one cycle, then IDLE.
- Arbitration:
  - cpu_ready = cpu_we && !(state==RUN && starve==STARVE_MAX).
  - In RUN, if cpu_ready the CPU gets the slot and starve++. Otherwise the fill gets the slot and starve=0.
  - Outside RUN, starve=0.
  - No cpu_we in RUN: the fill writes every cycle.
- CPU writes are passed through unchecked; cpu_addr >= 153600 is still issued.
- Simultaneous events:
  - fill_rq while busy or in DONE is ignored.
  - A CPU write and a fill pixel to the same address land in grant order (later write wins).
- Fill write count equals the clipped (x1-fill_x)*(y1-fill_y).

Optional Feature:
- Macro: VRAM_FILL_PATTERN_EN.
- With it: adds input fill_color2 (8 bits) and input fill_pat (1 bit), both latched with fill_rq. When fill_pat=1, a pixel gets fill_color2 where (cx^cy)&1 is 1, else fill_color (checkerboard).
- Without it: these ports are absent and every fill pixel is fill_color.

Test Plan:
- Full clear: fill (0,0,640,240, colour 0x00), no CPU traffic -> 153600 consecutive writes, addresses 0..153599, then fill_ack at cycle 153600+2 after fill_rq.
- Clip: fill (630,235,20,10, colour 0x5A) -> 10x5 = 50 writes. First address 235*640+630 = 151030, last 153599. Each row starts at +640.
- Empty: fill_w=0, and separately fill_x=700 -> no vmem_we, fill_ack 2 cycles after fill_rq.
- Starvation: cpu_we held high for the whole of a 4x4 fill with STARVE_MAX=4 -> pattern of 4 CPU writes then 1 fill write. cpu_ready is low exactly on the fill cycles. 16 fill writes total.
- Reset mid-fill: rst low for 1 cycle at fill pixel 100 -> outputs 0 immediately, no fill_ack. A new fill_rq after reset is accepted normally.
- fill_rq pulsed while busy -> ignored; exactly one fill_ack, and the write count matches the first request.
